// File: rtl/mem_master_pkg.sv
// Shared types and defaults for the word-memory initiator.
// Imported by mem_master and mem_beat_counter.
package mem_master_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_PULSE,
        RD_WAIT,
        RD_HOLD
    } state_t;

endpackage

// File: rtl/mem_beat_counter.sv
// Wrapping memory address plus beat count / last-beat flag.
// The address register is what drives the memory port directly.
module mem_beat_counter
    import mem_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr  <= '0;
            count <= '0;
            len_q <= '0;
        end else if (load) begin
            addr  <= start_addr;
            count <= '0;
            len_q <= len;
        end else if (advance) begin
            addr  <= addr + 1'b1;
            count <= count + 1'b1;
        end
    end

    assign last = (count == len_q);

endmodule

// File: rtl/mem_master.sv
// Single/burst read-write initiator for a combinational word memory.
// Write strobes (mem_read=0) are registered and last exactly one cycle.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LAT - 1);

    state_t state, state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic last;
    logic accept, wr_take, advance, finish, capture;

    mem_beat_counter #(.ADDR_W(ADDR_W)) u_beat (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .advance    (advance),
        .start_addr (req_addr),
        .len        (req_len),
        .addr       (mem_addr),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (accept) state_next = req_write ? WR_WAIT : RD_WAIT;
            WR_WAIT:  if (wr_take) state_next = WR_PULSE;
            WR_PULSE: state_next = last ? IDLE : WR_WAIT;
            RD_WAIT:  if (capture) state_next = RD_HOLD;
            RD_HOLD: begin
                if (finish)       state_next = IDLE;
                else if (advance) state_next = RD_WAIT;
            end
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        accept    = 1'b0;
        wr_take   = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            WR_WAIT: begin
                wr_ready = 1'b1;
                wr_take  = wr_valid;
            end
            WR_PULSE: begin
                advance = !last;
                finish  = last;
            end
            RD_WAIT:  capture = (lat_cnt == '0);
            RD_HOLD: begin
                advance = rd_valid && rd_ready && !last;
                finish  = rd_valid && rd_ready && last;
            end
            default: ;
        endcase
    end

    // Latency counter restarts whenever mem_addr takes a new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read <= 1'b1;
            mem_in   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            done     <= finish;
            mem_read <= !wr_take;
            if (wr_take) mem_in <= wr_data;
            if (accept || advance)
                lat_cnt <= LAT_INIT;
            else if (state == RD_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
            if (capture) begin
                rd_data  <= mem_out;
                rd_valid <= 1'b1;
            end else if (state == RD_HOLD && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: one DUT with READ_LAT=1, one with READ_LAT=3,
// each attached to a behavioural 32-word memory.
module tb_mem_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem[32];

    logic        req_valid, req_ready, req_write;
    logic [4:0]  req_addr, req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, mem_read;
    logic [4:0]  mem_addr;
    logic [31:0] mem_in, mem_out;

    logic        r3_req_valid, r3_req_ready, r3_req_write;
    logic [4:0]  r3_req_addr, r3_req_len;
    logic        r3_wr_ready, r3_rd_valid, r3_rd_ready, r3_done, r3_mem_read;
    logic [31:0] r3_rd_data, r3_mem_in, r3_mem_out;
    logic [4:0]  r3_mem_addr;

    mem_master #(.READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_read(mem_read), .mem_out(mem_out)
    );

    mem_master #(.READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(r3_req_valid), .req_ready(r3_req_ready), .req_write(r3_req_write),
        .req_addr(r3_req_addr), .req_len(r3_req_len),
        .wr_valid(1'b0), .wr_ready(r3_wr_ready), .wr_data(32'h0),
        .rd_valid(r3_rd_valid), .rd_ready(r3_rd_ready), .rd_data(r3_rd_data),
        .done(r3_done), .mem_addr(r3_mem_addr), .mem_in(r3_mem_in),
        .mem_read(r3_mem_read), .mem_out(r3_mem_out)
    );

    // Behavioural memories: write on the edge while read=0, combinational read.
    logic [31:0] mem1[32];
    logic [31:0] mem3[32];
    logic loaded = 1'b0;
    int npulse = 0;
    int long_pulse = 0;
    int npulse3 = 0;
    logic prev_low = 1'b0;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 32; i++) begin
                mem1[i] <= i;
                mem3[i] <= 32'hA5A5_0000 | i;
            end
            loaded <= 1'b1;
        end else begin
            if (mem_read === 1'b0) begin
                mem1[mem_addr] <= mem_in;
                npulse <= npulse + 1;
                if (prev_low) long_pulse <= long_pulse + 1;
            end
            if (r3_mem_read === 1'b0) begin
                mem3[r3_mem_addr] <= r3_mem_in;
                npulse3 <= npulse3 + 1;
            end
        end
        prev_low <= (mem_read === 1'b0);
    end

    assign mem_out    = mem1[mem_addr];
    assign r3_mem_out = mem3[r3_mem_addr];

    task automatic send_req(input logic w, input logic [4:0] a, input logic [4:0] l);
        int t;
        t = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        if (!req_ready) begin
            bad++; total++;
            $display("FAIL req_accept: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [31:0] d);
        int t;
        t = 0;
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && t < 50) begin @(negedge clk); t++; end
        if (!wr_ready) begin
            bad++; total++;
            $display("FAIL wr_accept: wr_ready=%b required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        total++;
        if (mem_read !== 1'b0) begin
            bad++;
            $display("FAIL wr_strobe: mem_read=%b required 0", mem_read);
        end
    endtask

    task automatic recv(input int n, input int stall_beat);
        int t;
        logic [31:0] hd, ex;
        logic [4:0] ha;
        for (int b = 0; b < n; b++) begin
            t = 0;
            while (!rd_valid && t < 50) begin @(negedge clk); t++; end
            if (!rd_valid) begin
                bad++; total++;
                $display("FAIL rd_timeout: beat %0d rd_valid=%b required 1", b, rd_valid);
                return;
            end
            if (b == stall_beat) begin
                hd = rd_data; ha = mem_addr;
                rd_ready = 1'b0;
                repeat (5) @(negedge clk);
                total++;
                if (rd_valid !== 1'b1 || rd_data !== hd || mem_addr !== ha) begin
                    bad++;
                    $display("FAIL rd_hold: valid=%b data=%h addr=%0d required 1 %h %0d",
                             rd_valid, rd_data, mem_addr, hd, ha);
                end
                rd_ready = 1'b1;
            end
            ex = exp_q.pop_front();
            total++;
            if (rd_data !== ex) begin
                bad++;
                $display("FAIL rd_data: beat %0d got %h required %h", b, rd_data, ex);
            end
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rd_done: done=%b left=%0d required 1 0", done, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (mem_read !== 1'b1 || req_ready !== 1'b1 || rd_valid !== 1'b0 ||
            done !== 1'b0 || mem_addr !== 5'd0) begin
            bad++;
            $display("FAIL reset: rd=%b rq=%b rv=%b dn=%b a=%0d required 1 1 0 0 0",
                     mem_read, req_ready, rd_valid, done, mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_single();
        exp_q.push_back(ref_mem[7]);
        send_req(1'b0, 5'd7, 5'd0);
        total++;
        if (rd_valid !== 1'b0 || mem_addr !== 5'd7) begin
            bad++;
            $display("FAIL rd1_early: rv=%b a=%0d required 0 7", rd_valid, mem_addr);
        end
        @(negedge clk);
        total++;
        if (rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL rd1_latency: rv=%b required 1", rd_valid);
        end
        recv(1, -1);
    endtask

    task automatic test_write_wrap();
        int p0;
        logic [31:0] d[4];
        logic [4:0] a;
        d[0] = 32'hAAAA_000A; d[1] = 32'hBBBB_000B;
        d[2] = 32'hCCCC_000C; d[3] = 32'hDDDD_000D;
        p0 = npulse;
        send_req(1'b1, 5'd30, 5'd3);
        for (int i = 0; i < 4; i++) begin
            a = 5'(30 + i);
            ref_mem[a] = d[i];
            send_wr(d[i]);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL wr_done: done=%b rq=%b required 1 1", done, req_ready);
        end
        @(negedge clk);
        total++;
        if (npulse - p0 != 4 || long_pulse != 0) begin
            bad++;
            $display("FAIL wr_pulses: n=%0d long=%0d required 4 0", npulse - p0, long_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            a = 5'(30 + i);
            total++;
            if (mem1[a] !== d[i]) begin
                bad++;
                $display("FAIL wr_mem: mem[%0d]=%h required %h", a, mem1[a], d[i]);
            end
            exp_q.push_back(d[i]);
        end
        send_req(1'b0, 5'd30, 5'd3);
        recv(4, -1);
    endtask

    task automatic test_stall();
        for (int i = 10; i < 14; i++) exp_q.push_back(ref_mem[i]);
        @(negedge clk);
        send_req(1'b0, 5'd10, 5'd3);
        recv(4, 1);
    endtask

    task automatic test_reset_mid_write();
        int p0;
        p0 = npulse;
        @(negedge clk);
        send_req(1'b1, 5'd5, 5'd3);
        ref_mem[5] = 32'h1111_0005; send_wr(32'h1111_0005);
        ref_mem[6] = 32'h2222_0006; send_wr(32'h2222_0006);
        @(negedge clk);
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_wr_wait: wr_ready=%b required 1", wr_ready);
        end
        reset = 1'b1; wr_valid = 1'b1; wr_data = 32'h3333_0007;
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b0;
        total++;
        if (mem_read !== 1'b1 || req_ready !== 1'b1 || mem_addr !== 5'd0) begin
            bad++;
            $display("FAIL rst_abort: rd=%b rq=%b a=%0d required 1 1 0",
                     mem_read, req_ready, mem_addr);
        end
        repeat (2) @(negedge clk);
        for (int i = 5; i < 9; i++) begin
            total++;
            if (mem1[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL rst_mem: mem[%0d]=%h required %h", i, mem1[i], ref_mem[i]);
            end
        end
        total++;
        if (npulse - p0 != 2 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL rst_pulses: n=%0d rd=%b required 2 1", npulse - p0, mem_read);
        end
    endtask

    task automatic test_lat3();
        int c;
        logic [31:0] ex;
        for (int i = 20; i < 23; i++) exp_q.push_back(32'hA5A5_0000 | i);
        r3_req_valid = 1'b1; r3_req_write = 1'b0; r3_req_addr = 5'd20; r3_req_len = 5'd2;
        total++;
        if (r3_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL l3_idle: req_ready=%b required 1", r3_req_ready);
        end
        @(negedge clk);
        r3_req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            c = 0;
            if (b == 1) begin
                r3_req_valid = 1'b1; r3_req_write = 1'b1; r3_req_addr = 5'd3;
                total++;
                if (r3_req_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL l3_busy: req_ready=%b required 0", r3_req_ready);
                end
            end
            while (!r3_rd_valid && c < 20) begin @(negedge clk); c++; end
            r3_req_valid = 1'b0;
            total++;
            if (c != 3 || r3_mem_addr !== 5'(20 + b)) begin
                bad++;
                $display("FAIL l3_latency: beat %0d cycles=%0d a=%0d required 3 %0d",
                         b, c, r3_mem_addr, 20 + b);
            end
            ex = exp_q.pop_front();
            total++;
            if (r3_rd_data !== ex) begin
                bad++;
                $display("FAIL l3_data: beat %0d got %h required %h", b, r3_rd_data, ex);
            end
            @(negedge clk);
        end
        total++;
        if (r3_done !== 1'b1) begin
            bad++;
            $display("FAIL l3_done: done=%b required 1", r3_done);
        end
        repeat (3) @(negedge clk);
        total++;
        if (r3_req_ready !== 1'b1 || r3_wr_ready !== 1'b0 || npulse3 != 0) begin
            bad++;
            $display("FAIL l3_ignored: rq=%b wr=%b pulses=%0d required 1 0 0",
                     r3_req_ready, r3_wr_ready, npulse3);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
        r3_req_valid = 1'b0; r3_req_write = 1'b0; r3_req_addr = '0; r3_req_len = '0;
        r3_rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = i;
        test_reset();
        test_read_single();
        test_write_wrap();
        test_stall();
        test_reset_mid_write();
        test_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
